// File: rtl/ins_unswap.sv
// ins_unswap: undoes the issue-stage slot swap on returning lane results.
// Optional retired-swap counter is enabled by defining INS_UNSWAP_CNT_EN.
module ins_unswap #(
    parameter int DEPTH  = 4,
    parameter int DES_W  = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue_vld,
    input  logic [3:0]        issue_swap,
    output logic              issue_rdy,
    input  logic              res_vld,
    output logic              res_rdy,
    input  logic              res_1_vld,
    input  logic [DES_W-1:0]  res_1_des,
    input  logic [DATA_W-1:0] res_1_data,
    input  logic              res_2_vld,
    input  logic [DES_W-1:0]  res_2_des,
    input  logic [DATA_W-1:0] res_2_data,
    input  logic              res_3_vld,
    input  logic [DES_W-1:0]  res_3_des,
    input  logic [DATA_W-1:0] res_3_data,
    input  logic              res_4_vld,
    input  logic [DES_W-1:0]  res_4_des,
    input  logic [DATA_W-1:0] res_4_data,
    output logic              wb_vld,
    input  logic              wb_rdy,
    output logic              wb_1_vld,
    output logic [DES_W-1:0]  wb_1_des,
    output logic [DATA_W-1:0] wb_1_data,
    output logic              wb_2_vld,
    output logic [DES_W-1:0]  wb_2_des,
    output logic [DATA_W-1:0] wb_2_data,
    output logic              wb_3_vld,
    output logic [DES_W-1:0]  wb_3_des,
    output logic [DATA_W-1:0] wb_3_data,
    output logic              wb_4_vld,
    output logic [DES_W-1:0]  wb_4_des,
    output logic [DATA_W-1:0] wb_4_data,
    output logic [15:0]       swap_cnt
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [3:0]       code_mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [3:0]       head_code;
    logic             push;
    logic             pop;

    // lane-indexed views; index 0 is lane/slot 1
    logic [3:0]             in_vld;
    logic [3:0][DES_W-1:0]  in_des;
    logic [3:0][DATA_W-1:0] in_data;
    logic [3:0][1:0]        src;
    logic [3:0]             perm_vld;
    logic [3:0][DES_W-1:0]  perm_des;
    logic [3:0][DATA_W-1:0] perm_data;
    logic [3:0]             wb_vld_q;
    logic [3:0][DES_W-1:0]  wb_des_q;
    logic [3:0][DATA_W-1:0] wb_data_q;

    assign issue_rdy = !rst && (count < CNT_FULL);
    assign res_rdy   = !rst && (count != '0) && (!wb_vld || wb_rdy);
    assign push      = issue_vld && issue_rdy;
    assign pop       = res_vld && res_rdy;
    assign head_code = code_mem[rd_ptr];

    assign in_vld  = {res_4_vld, res_3_vld, res_2_vld, res_1_vld};
    assign in_des  = {res_4_des, res_3_des, res_2_des, res_1_des};
    assign in_data = {res_4_data, res_3_data, res_2_data, res_1_data};

    // store the swap code of each issued bundle; entries need no reset
    always_ff @(posedge clk) begin
        if (push) begin
            code_mem[wr_ptr] <= issue_swap;
        end
    end

    // FIFO pointers and occupancy, wrapping modulo DEPTH
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // each swap is its own inverse: pick the source lane for every slot
    always_comb begin
        src[0] = 2'd0;
        src[1] = 2'd1;
        src[2] = 2'd2;
        src[3] = 2'd3;
        case (head_code)
            4'b1001: begin
                src[0] = 2'd3;
                src[3] = 2'd0;
            end
            4'b1100: begin
                src[0] = 2'd1;
                src[1] = 2'd0;
            end
            4'b1010: begin
                src[0] = 2'd2;
                src[2] = 2'd0;
            end
            default: begin
                src[0] = 2'd0;
            end
        endcase
    end

    // move vld/des/data of a lane as one unit
    always_comb begin
        perm_vld  = '0;
        perm_des  = '0;
        perm_data = '0;
        for (int k = 0; k < 4; k++) begin
            perm_vld[k]  = in_vld[src[k]];
            perm_des[k]  = in_des[src[k]];
            perm_data[k] = in_data[src[k]];
        end
    end

    // write-back register: load on accept, hold under backpressure
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_vld    <= 1'b0;
            wb_vld_q  <= '0;
            wb_des_q  <= '0;
            wb_data_q <= '0;
        end else if (pop) begin
            wb_vld    <= 1'b1;
            wb_vld_q  <= perm_vld;
            wb_des_q  <= perm_des;
            wb_data_q <= perm_data;
        end else if (wb_rdy) begin
            wb_vld <= 1'b0;
        end
    end

    assign wb_1_vld  = wb_vld_q[0];
    assign wb_2_vld  = wb_vld_q[1];
    assign wb_3_vld  = wb_vld_q[2];
    assign wb_4_vld  = wb_vld_q[3];
    assign wb_1_des  = wb_des_q[0];
    assign wb_2_des  = wb_des_q[1];
    assign wb_3_des  = wb_des_q[2];
    assign wb_4_des  = wb_des_q[3];
    assign wb_1_data = wb_data_q[0];
    assign wb_2_data = wb_data_q[1];
    assign wb_3_data = wb_data_q[2];
    assign wb_4_data = wb_data_q[3];

`ifdef INS_UNSWAP_CNT_EN
    logic [15:0] cnt_q;
    logic        is_swap;

    assign is_swap = (head_code == 4'b1001) ||
                     (head_code == 4'b1100) ||
                     (head_code == 4'b1010);

    // saturating count of retired non-identity bundles
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (pop && is_swap && (cnt_q != 16'hFFFF)) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    assign swap_cnt = cnt_q;
`else
    assign swap_cnt = 16'h0000;
`endif

endmodule
